// File: rtl/i2s_rx.sv
// I2S slave receiver: samples bit clock, word select and data in the system clock domain.
// Emits each coherent left/right pair with a strobe, plus a hysteresis "ear" bit from the left channel.
module i2s_rx #(
  parameter int DW = 16,
  parameter logic signed [DW-1:0] HI = 16'sh0400,
  parameter logic signed [DW-1:0] LO = -16'sh0400
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          sck,
  input  logic          lr,
  input  logic          d,
  output logic [DW-1:0] ldata,
  output logic [DW-1:0] rdata,
  output logic          strobe,
  output logic          ear
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [DW-1:0] MSB = {1'b1, {(DW-1){1'b0}}};

  logic          sck_s1_q, sck_s2_q, sck_s3_q;
  logic          lr_s1_q, lr_s2_q;
  logic          d_s1_q, d_s2_q;
  logic [DW-1:0] sh_q;
  logic [CW-1:0] cnt_q;
  logic          ch_q;
  logic          started_q;
  logic          lvalid_q;
  logic [DW-1:0] pend_q;
  logic [DW-1:0] ldata_q, rdata_q;
  logic          strobe_q;
  logic          ear_q;

  logic          rise;
  logic          lr_chg;
  logic [DW-1:0] mask;
  logic [DW-1:0] word_d;
  logic          ear_d;

  // mask shifts out to zero once cnt saturates, so extra slot bits drop
  always_comb begin
    rise   = sck_s2_q & ~sck_s3_q;
    lr_chg = rise & (lr_s2_q != ch_q);
    mask   = MSB >> cnt_q;
    word_d = d_s2_q ? (sh_q | mask) : sh_q;
    ear_d  = ear_q;
    if ($signed(ldata_q) > HI)
      ear_d = 1'b1;
    else if ($signed(ldata_q) < LO)
      ear_d = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_s1_q  <= 1'b0;
      sck_s2_q  <= 1'b0;
      sck_s3_q  <= 1'b0;
      lr_s1_q   <= 1'b0;
      lr_s2_q   <= 1'b0;
      d_s1_q    <= 1'b0;
      d_s2_q    <= 1'b0;
      sh_q      <= '0;
      cnt_q     <= '0;
      ch_q      <= 1'b0;
      started_q <= 1'b0;
      lvalid_q  <= 1'b0;
      pend_q    <= '0;
      ldata_q   <= '0;
      rdata_q   <= '0;
      strobe_q  <= 1'b0;
      ear_q     <= 1'b0;
    end else begin
      sck_s1_q <= sck;
      sck_s2_q <= sck_s1_q;
      sck_s3_q <= sck_s2_q;
      lr_s1_q  <= lr;
      lr_s2_q  <= lr_s1_q;
      d_s1_q   <= d;
      d_s2_q   <= d_s1_q;
      strobe_q <= 1'b0;
      if (strobe_q)
        ear_q <= ear_d;
      if (rise) begin
        if (!lr_chg) begin
          sh_q <= word_d;
          if (cnt_q < CW'(DW))
            cnt_q <= cnt_q + CW'(1);
        end else begin
          sh_q      <= '0;
          cnt_q     <= '0;
          ch_q      <= lr_s2_q;
          started_q <= 1'b1;
          // words whose start boundary was not seen are dropped
          if (started_q) begin
            if (!ch_q) begin
              pend_q   <= word_d;
              lvalid_q <= 1'b1;
            end else if (lvalid_q) begin
              ldata_q  <= pend_q;
              rdata_q  <= word_d;
              strobe_q <= 1'b1;
              lvalid_q <= 1'b0;
            end
          end
        end
      end
    end
  end

  assign ldata  = ldata_q;
  assign rdata  = rdata_q;
  assign strobe = strobe_q;
  assign ear    = ear_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: framing, truncation, zero fill,
// startup alignment, async reset, latency and ear hysteresis.
module tb_i2s_rx;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sck = 1'b0;
  logic        lr = 1'b0;
  logic        d = 1'b0;
  logic [15:0] ldata, rdata;
  logic        strobe, ear;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_cyc = 0;
  bit jit = 1'b0;
  int dbl = 0;
  bit prev_s = 1'b0;
  bit pend_e = 1'b0;

  logic [15:0] sl[$];
  logic [15:0] sr[$];
  int          slat[$];
  logic        es[$];
  logic        ea[$];

  i2s_rx dut (
    .clock (clock),
    .reset (reset),
    .sck   (sck),
    .lr    (lr),
    .d     (d),
    .ldata (ldata),
    .rdata (rdata),
    .strobe(strobe),
    .ear   (ear)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (pend_e) ea.push_back(ear);
    pend_e <= strobe;
    if (strobe) begin
      sl.push_back(ldata);
      sr.push_back(rdata);
      slat.push_back(cyc - rise_cyc);
      es.push_back(ear);
    end
    if (strobe && prev_s) dbl <= dbl + 1;
    prev_s <= strobe;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bit_slot(input logic lv, input logic bv);
    int h;
    int l;
    h = 3;
    l = 5;
    if (jit) begin
      h = 3 + int'($urandom_range(1, 0));
      l = 5 + int'($urandom_range(1, 0));
    end
    sck = 1'b0;
    lr = lv;
    d = bv;
    repeat (l) @(negedge clock);
    sck = 1'b1;
    rise_cyc = cyc;
    repeat (h) @(negedge clock);
  endtask

  // LSB of each word goes out with the next word's lr value
  task automatic send_word(input logic own, input logic nxt,
                           input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--)
      bit_slot((i == 0) ? nxt : own, w[i]);
  endtask

  task automatic frames(input logic [31:0] lw, input logic [31:0] rw,
                        input int n, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      send_word(1'b0, 1'b1, lw, n);
      send_word(1'b1, 1'b0, rw, n);
    end
  endtask

  task automatic preamble(input int n);
    send_word(1'b1, 1'b0, 32'h0, n);
  endtask

  task automatic clr();
    sl.delete();
    sr.delete();
    slat.delete();
    es.delete();
    ea.delete();
  endtask

  task automatic drain();
    repeat (8) @(negedge clock);
  endtask

  task automatic rst_pulse();
    @(negedge clock);
    sck = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic chk_pairs(input string tag, input int n,
                           input logic [15:0] el, input logic [15:0] er);
    for (int i = 0; i < n; i++) begin
      if (i < sl.size()) begin
        chk({tag, "_l"}, 32'(sl[i]), 32'(el));
        chk({tag, "_r"}, 32'(sr[i]), 32'(er));
      end
    end
  endtask

  logic [31:0] wv;
  logic [31:0] ev_l[6];
  logic        ev_es[6];
  logic        ev_ea[6];

  initial begin
    ev_l  = '{32'h1000, 32'h0000, 32'h0400, 32'hF000, 32'hFC00, 32'h0401};
    ev_es = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ev_ea = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    repeat (3) @(negedge clock);
    chk("rst_ldata", 32'(ldata), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_strobe", 32'(strobe), 32'h0);
    chk("rst_ear", 32'(ear), 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    clr();
    preamble(32);
    frames(32'h7FFF_1234, 32'h8001_ABCD, 32, 3);
    drain();
    chk("basic_cnt", 32'(sl.size()), 32'd3);
    chk_pairs("basic", 3, 16'h7FFF, 16'h8001);
    for (int i = 0; i < 3; i++)
      if (i < slat.size()) chk("basic_lat", 32'(slat[i]), 32'd3);

    clr();
    wv = 32'h1357_2468;
    for (int i = 0; i < 6; i++) bit_slot(1'b0, wv[31-i]);
    sck = 1'b0;
    lr = 1'b0;
    d = wv[25];
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ldata", 32'(ldata), 32'h0);
    chk("midrst_rdata", 32'(rdata), 32'h0);
    chk("midrst_ear", 32'(ear), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    sck = 1'b1;
    rise_cyc = cyc;
    repeat (3) @(negedge clock);
    send_word(1'b0, 1'b1, wv, 25);
    send_word(1'b1, 1'b0, 32'hAAAA_0000, 32);
    frames(32'h1111_0000, 32'h2222_0000, 32, 1);
    drain();
    chk("midrst_cnt", 32'(sl.size()), 32'd1);
    chk_pairs("midrst", 1, 16'h1111, 16'h2222);

    rst_pulse();
    clr();
    preamble(12);
    frames(32'h0000_0ABC, 32'h0000_0123, 12, 2);
    drain();
    chk("short_cnt", 32'(sl.size()), 32'd2);
    chk_pairs("short", 2, 16'hABC0, 16'h1230);

    rst_pulse();
    clr();
    send_word(1'b1, 1'b0, 32'h0000_0155, 10);
    frames(32'h3C3C_0000, 32'hC3C3_0000, 32, 1);
    frames(32'h0F0F_0000, 32'hF0F0_0000, 32, 1);
    drain();
    chk("start_cnt", 32'(sl.size()), 32'd2);
    chk_pairs("start_first", 1, 16'h3C3C, 16'hC3C3);
    if (sl.size() > 1) begin
      chk("start_second_l", 32'(sl[1]), 32'h0F0F);
      chk("start_second_r", 32'(sr[1]), 32'hF0F0);
    end

    rst_pulse();
    clr();
    preamble(16);
    for (int k = 0; k < 6; k++) frames(ev_l[k], 32'h5A5A, 16, 1);
    drain();
    chk("ear_cnt", 32'(sl.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < sl.size()) begin
        chk("ear_ldata", 32'(sl[k]), 32'(ev_l[k][15:0]));
        chk("ear_at_strobe", 32'(es[k]), 32'(ev_es[k]));
      end
      if (k < ea.size()) chk("ear_after", 32'(ea[k]), 32'(ev_ea[k]));
    end

    rst_pulse();
    jit = 1'b1;
    clr();
    preamble(32);
    frames(32'h7FFF_1234, 32'h8001_ABCD, 32, 3);
    drain();
    jit = 1'b0;
    chk("jit_cnt", 32'(sl.size()), 32'd3);
    chk_pairs("jit", 3, 16'h7FFF, 16'h8001);

    chk("no_back_to_back", 32'(dbl), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver (slave) for the codec ADC return path (AUDIO_DOUT_MFP2).
- The fabric-side I2S transmitter generates bit clock and word select. This block samples them as ordinary inputs in the system clock domain.
- It deserialises left/right words and presents each coherent stereo pair with a one-cycle strobe.
- It also derives a tape "ear" bit from the left channel using a hysteresis comparator, so the core can load tapes through the codec line input.

Parameters:
DW, 16, captured word width (bits kept per channel, MSB first)
HI, 16'sh0400, signed threshold (DW bits); left sample > HI sets ear
LO, -16'sh0400, signed threshold (DW bits); left sample < LO clears ear; HI > LO required

Ports:
clock  in  1  system clock (56 MHz)
reset  in  1  asynchronous, active-high reset
sck    in  1  I2S bit clock
lr     in  1  I2S word select; 0 = left, 1 = right
d      in  1  I2S serial data from codec
ldata  out DW  left sample of last complete pair, two's complement
rdata  out DW  right sample of last complete pair
strobe out 1   one-cycle pulse when ldata/rdata update
ear    out 1   hysteresis-filtered sign of left channel

Behaviour:
- Reset (async, active-high): ldata=0, rdata=0, strobe=0, ear=0. Synchronisers, shift register, bit counter, channel and validity flags all clear. No output change until a full new pair is received after release.
- Synchronisation:
  - sck, lr, d each pass through two flops (s1, s2); sck gets a third flop s3.
  - rise = s2_sck & ~s3_sck.
  - lr and d are sampled from their s2 stage only when rise=1, so all three have equal delay.
- Input timing: sck high and low phases are each >= 3 clock periods. Faster input gives undefined results.
- I2S framing:
  - The codec changes lr and d on falling sck.
  - The first rise with sampled lr != current channel register (ch) carries the last bit (LSB slot) of the previous word.
  - The next rise carries the MSB of the new word.
- Per rise, no lr change:
  - If cnt < DW: store bit at index DW-1-cnt, then cnt++.
  - cnt saturates at DW; extra slot bits are ignored (truncation).
- Per rise, lr change:
  - Append the bit as above if cnt < DW.
  - Finalise the word of channel ch. Unfilled LSBs stay 0, i.e. left-justified zero fill; a 12-bit slot with DW=16 yields value<<4.
  - Then clear the shift register, set cnt=0, ch<=sampled lr, started<=1.
- Word validity: a finalised word is valid only if started was 1 before that edge, i.e. its start boundary was observed after reset. Invalid words are discarded.
- Finalising left (ch=0): word goes to a pending register; lvalid<=1.
- Finalising right (ch=1):
  - If lvalid=1: ldata<=pending, rdata<=word, strobe<=1 for exactly one cycle, lvalid<=0.
  - If lvalid=0: discard; no strobe.
- Latency: strobe is high in the cycle after the 2nd clock edge following the edge at which s1_sck first registers the high level. ldata and rdata change on that same edge.
- Ear comparator:
  - Updates on the edge after strobe, using the registered ldata as a signed value.
  - ldata > HI: ear<=1. ldata < LO: ear<=0. Otherwise hold.
  - Equality to a threshold holds.
- Only one event per rise; strobe can never be asserted on consecutive cycles.

Test Plan:
- Reset mid-word: assert reset during the 7th bit of a left word. Outputs are 0 within the same cycle (async). After release, the first strobe follows the first complete L+R pair that starts after an observed lr edge.
- Basic frame: 32-bit slots, L=0x7FFF_xxxx, R=0x8001_xxxx, 3 frames. Exactly 3 strobes, each one cycle wide, with ldata=0x7FFF and rdata=0x8001. Bench checks the 2-edge latency from s1_sck high.
- Short slot: 12-bit slots, L=0xABC, R=0x123. Result ldata=0xABC0, rdata=0x1230.
- Startup alignment: release reset in the middle of a right word. The partial right word and the following left-less right word give no strobe. The first strobe carries the first fully framed left then right pair.
- Ear hysteresis with defaults, left sequence +0x1000, 0x0000, +0x0400, -0x1000, -0x0400, +0x0401. Ear goes 1, 1, 1, 0, 0, 1; each update lands one cycle after its strobe.
- Slow/irregular sck: sck high 3 clocks / low 5 clocks, jitter ±1 clock above the minimum. Samples are identical to the regular-sck case and there are no spurious strobes.
